// File: rtl/key_event_arb.sv
// key_event_arb
// Serialises single-cycle press/release pulses from N debounced switches into
// one ordered event stream. Each source owns a one-entry pending slot; a
// round-robin arbiter moves one pending slot per cycle into a small event
// FIFO whose head sits in output flops.
//
// Optional feature macro: KEY_EVT_RELEASE_EN
//   defined   : sw_lo pulses are captured and reported with evt_press = 0
//   undefined : sw_lo is ignored, no type bit is stored, evt_press is tied 1
//
// Handshake: an event transfers on a rising clk50m edge where evt_valid and
// evt_ready are both high; while evt_valid is high and evt_ready is low the
// head (evt_id, evt_press) holds still, and evt_valid never drops without a
// transfer. evt_valid does not depend combinationally on evt_ready.

module key_event_arb #(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int IDW   = $clog2(N)
) (
    input  logic           rst_n,
    input  logic           clk50m,
    input  logic [N-1:0]   sw_hi,
    input  logic [N-1:0]   sw_lo,
    output logic           evt_valid,
    input  logic           evt_ready,
    output logic [IDW-1:0] evt_id,
    output logic           evt_press,
    output logic           ovf,
    input  logic           ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Per-source pending slots
    logic [N-1:0]   pend_v_q, pend_v_d;
`ifdef KEY_EVT_RELEASE_EN
    logic [N-1:0]   pend_t_q, pend_t_d;
`endif

    // Round-robin search start
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    // FIFO body behind the head register. The head holds one event, so the
    // body never holds more than DEPTH-1; it is sized DEPTH to keep the
    // pointers power-of-two wrapping.
    logic [IDW-1:0] mem_id_q [DEPTH];
`ifdef KEY_EVT_RELEASE_EN
    logic           mem_t_q  [DEPTH];
`endif
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  mem_cnt_q, mem_cnt_d;

    // Head of FIFO, driven straight onto the outputs
    logic           evt_valid_q, evt_valid_d;
    logic [IDW-1:0] evt_id_q, evt_id_d;
`ifdef KEY_EVT_RELEASE_EN
    logic           evt_press_q, evt_press_d;
`endif

    logic           ovf_q, ovf_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [N-1:0]   pulse;
    logic [CW-1:0]  occ;
    logic           fifo_full;
    logic           grant;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_t;
    logic           drop;
    logic           refill;
    logic           mem_empty;
    logic           mem_pop;
    logic           mem_push;
    logic           bypass;

    // Which sources raised a pulse this cycle (releases only when enabled)
`ifdef KEY_EVT_RELEASE_EN
    assign pulse = sw_hi | sw_lo;
`else
    assign pulse = sw_hi;
    // sw_lo has no function in this build
    logic unused_sw_lo;
    assign unused_sw_lo = ^sw_lo;
`endif

    // Total events held (head + body). The grant decision uses this
    // registered count, so a pop does not free space in the same cycle.
    assign occ       = mem_cnt_q + CW'(evt_valid_q);
    assign fifo_full = (occ == CW'(DEPTH));

    // Round-robin arbiter: first pending slot at or after rr_ptr, wrapping
    always_comb begin
        int             j;
        logic [IDW-1:0] idx;
        grant   = 1'b0;
        gnt_idx = '0;
        j       = 0;
        idx     = '0;
        if (!fifo_full) begin
            for (int k = 0; k < N; k++) begin
                j = int'(rr_ptr_q) + k;
                if (j >= N) begin
                    j = j - N;
                end
                idx = IDW'(j);
                if (!grant && pend_v_q[idx]) begin
                    grant   = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
    end

    // Type of the granted event
`ifdef KEY_EVT_RELEASE_EN
    assign gnt_t = pend_t_q[gnt_idx];
`else
    assign gnt_t = 1'b1;
`endif

    // Pointer moves one past the winner; unchanged when nothing is granted
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            if (gnt_idx == IDW'(N - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + 1'b1;
            end
        end
    end

    // Slot update: a pulse loads a free slot or one being granted now;
    // a pulse into a slot that stays occupied is lost and flagged
    always_comb begin
        logic granted;
        pend_v_d = pend_v_q;
`ifdef KEY_EVT_RELEASE_EN
        pend_t_d = pend_t_q;
`endif
        drop     = 1'b0;
        granted  = 1'b0;
        for (int i = 0; i < N; i++) begin
            granted = grant && (gnt_idx == IDW'(i));
            if (pulse[i]) begin
                if (!pend_v_q[i] || granted) begin
                    pend_v_d[i] = 1'b1;
`ifdef KEY_EVT_RELEASE_EN
                    pend_t_d[i] = sw_hi[i];
`endif
                end else begin
                    drop = 1'b1;
                end
            end else if (granted) begin
                pend_v_d[i] = 1'b0;
            end
        end
    end

    // Sticky overflow; a new loss wins over a simultaneous clear
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // FIFO control: the head refills when empty or being consumed, taking
    // the oldest body entry, or the granted event directly when the body
    // is empty (this is what gives the 2-clock pulse-to-valid latency)
    assign refill    = !evt_valid_q || evt_ready;
    assign mem_empty = (mem_cnt_q == '0);
    assign mem_pop   = refill && !mem_empty;
    assign bypass    = refill && mem_empty && grant;
    assign mem_push  = grant && !bypass;

    // Next head contents and body bookkeeping
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
`ifdef KEY_EVT_RELEASE_EN
        evt_press_d = evt_press_q;
`endif
        if (refill) begin
            evt_valid_d = !mem_empty || grant;
            if (mem_pop) begin
                evt_id_d    = mem_id_q[rd_ptr_q];
`ifdef KEY_EVT_RELEASE_EN
                evt_press_d = mem_t_q[rd_ptr_q];
`endif
            end else if (bypass) begin
                evt_id_d    = gnt_idx;
`ifdef KEY_EVT_RELEASE_EN
                evt_press_d = gnt_t;
`endif
            end
        end
        wr_ptr_d  = mem_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = mem_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        mem_cnt_d = mem_cnt_q + CW'(mem_push) - CW'(mem_pop);
    end

`ifndef KEY_EVT_RELEASE_EN
    // Type bit is constant in the press-only build
    logic unused_gnt_t;
    assign unused_gnt_t = gnt_t;
`endif

    // Control state; reset drops every pending and queued event at once
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_q    <= '0;
`ifdef KEY_EVT_RELEASE_EN
            pend_t_q    <= '0;
            evt_press_q <= 1'b0;
`endif
            rr_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            pend_v_q    <= pend_v_d;
`ifdef KEY_EVT_RELEASE_EN
            pend_t_q    <= pend_t_d;
            evt_press_q <= evt_press_d;
`endif
            rr_ptr_q    <= rr_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            ovf_q       <= ovf_d;
        end
    end

    // FIFO body storage; contents are only meaningful below mem_cnt_q
    always_ff @(posedge clk50m) begin
        if (mem_push) begin
            mem_id_q[wr_ptr_q] <= gnt_idx;
`ifdef KEY_EVT_RELEASE_EN
            mem_t_q[wr_ptr_q]  <= gnt_t;
`endif
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign ovf       = ovf_q;
`ifdef KEY_EVT_RELEASE_EN
    assign evt_press = evt_press_q;
`else
    assign evt_press = 1'b1;
`endif

endmodule

// File: tb/tb_key_event_arb.sv
// Testbench for key_event_arb (N = 4, DEPTH = 4). Honours KEY_EVT_RELEASE_EN
// the same way the design does.

module tb_key_event_arb;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int IDW   = 2;
    localparam int W     = IDW + 1;

`ifdef KEY_EVT_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic           clk50m = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   sw_hi = '0;
    logic [N-1:0]   sw_lo = '0;
    logic           evt_ready = 1'b0;
    logic           ovf_clr = 1'b0;
    logic           evt_valid;
    logic [IDW-1:0] evt_id;
    logic           evt_press;
    logic           ovf;

    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   mon_e;
    int             n_vec = 0;
    int             n_err = 0;

    key_event_arb #(.N(N), .DEPTH(DEPTH)) dut (
        .rst_n     (rst_n),
        .clk50m    (clk50m),
        .sw_hi     (sw_hi),
        .sw_lo     (sw_lo),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_press (evt_press),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    // ---------------- clock ----------------
    always #10 clk50m = ~clk50m;

    // ---------------- scoreboard: compare each accepted event ----------------
    always @(negedge clk50m) begin
        if (rst_n && evt_valid && evt_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got id=%0d press=%0b, required no event", evt_id, evt_press);
            end else begin
                mon_e = exp_q.pop_front();
                if ({evt_id, evt_press} !== mon_e) begin
                    n_err++;
                    $display("FAIL sb_event: got id=%0d press=%0b, required id=%0d press=%0b",
                             evt_id, evt_press, mon_e[W-1:1], mon_e[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk50m);
        #1;
    endtask

    task automatic do_reset();
        sw_hi     = '0;
        sw_lo     = '0;
        ovf_clr   = 1'b0;
        evt_ready = 1'b0;
        rst_n     = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_hi(input logic [N-1:0] m);
        sw_hi = m;
        tick();
        sw_hi = '0;
    endtask

    task automatic pulse_lo(input logic [N-1:0] m);
        sw_lo = m;
        tick();
        sw_lo = '0;
    endtask

    task automatic push_exp(input int id, input logic press);
        exp_q.push_back({IDW'(id), press});
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick();
        tick();
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic exp_press;
        exp_press = REL ? 1'b0 : 1'b1;
        rst_n = 1'b0;
        #5;
        n_vec++;
        if ({evt_valid, evt_id, ovf} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%0b id=%0d ovf=%0b, required 0 0 0", evt_valid, evt_id, ovf);
        end
        n_vec++;
        if (evt_press !== exp_press) begin
            n_err++;
            $display("FAIL reset_press: got %0b, required %0b", evt_press, exp_press);
        end
        do_reset();
        tick();
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_valid: got %0b, required 0", evt_valid);
        end
    endtask

    task automatic test_single_press();
        do_reset();
        push_exp(2, 1'b1);
        pulse_hi(4'b0100);
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_latency_e0: got valid=%0b, required 0", evt_valid);
        end
        tick();
        n_vec++;
        if ({evt_valid, evt_id, evt_press} !== {1'b1, 2'd2, 1'b1}) begin
            n_err++;
            $display("FAIL single_latency_e1: got valid=%0b id=%0d press=%0b, required 1 2 1",
                     evt_valid, evt_id, evt_press);
        end
        evt_ready = 1'b1;
        tick();
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_pop: got valid=%0b, required 0", evt_valid);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL single_drain: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_simultaneous();
        logic [IDW-1:0] ids [3];
        ids[0] = 2'd0;
        ids[1] = 2'd1;
        ids[2] = 2'd3;
        do_reset();
        evt_ready = 1'b1;
        push_exp(0, 1'b1);
        push_exp(1, 1'b1);
        push_exp(3, 1'b1);
        pulse_hi(4'b1011);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if ({evt_valid, evt_id} !== {1'b1, ids[k]}) begin
                n_err++;
                $display("FAIL simul_order[%0d]: got valid=%0b id=%0d, required 1 %0d", k, evt_valid, evt_id, ids[k]);
            end
        end
        tick();
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL simul_end: got valid=%0b, required 0", evt_valid);
        end
        // rr_ptr is back at 0, so the next burst on 0 and 3 starts at 0
        push_exp(0, 1'b1);
        push_exp(3, 1'b1);
        pulse_hi(4'b1001);
        wait_drain();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL simul_drain: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        evt_ready = 1'b1;
        push_exp(0, 1'b1);
        pulse_hi(4'b0001);
        tick();
        tick();
        tick();
        // rr_ptr = 1 now: 3 wins over 0, and again after 0 is served
        for (int b = 0; b < 2; b++) begin
            push_exp(3, 1'b1);
            push_exp(0, 1'b1);
            pulse_hi(4'b1001);
            tick();
            tick();
            tick();
        end
        wait_drain();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rr_drain: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_grant_cycle_capture();
        do_reset();
        evt_ready = 1'b1;
        push_exp(2, 1'b1);
        push_exp(2, 1'b1);
        sw_hi = 4'b0100;
        tick();
        tick();
        sw_hi = '0;
        wait_drain();
        n_vec++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL grant_capture_ovf: got %0b, required 0", ovf);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL grant_capture_drain: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) push_exp(i, 1'b1);
        pulse_hi(4'b1111);
        for (int i = 0; i < 4; i++) tick();
        n_vec++;
        if ({evt_valid, evt_id, ovf} !== {1'b1, 2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL bp_full: got valid=%0b id=%0d ovf=%0b, required 1 0 0", evt_valid, evt_id, ovf);
        end
        push_exp(1, 1'b1);
        pulse_hi(4'b0010);
        n_vec++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL bp_slot_wait: got ovf=%0b, required 0", ovf);
        end
        pulse_hi(4'b0010);
        n_vec++;
        if (ovf !== 1'b1) begin
            n_err++;
            $display("FAIL bp_overflow: got ovf=%0b, required 1", ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_vec++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL bp_clear: got ovf=%0b, required 0", ovf);
        end
        sw_hi   = 4'b0010;
        ovf_clr = 1'b1;
        tick();
        sw_hi   = '0;
        ovf_clr = 1'b0;
        n_vec++;
        if (ovf !== 1'b1) begin
            n_err++;
            $display("FAIL bp_set_over_clear: got ovf=%0b, required 1", ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        // A release into the occupied slot is lost only when releases exist
        pulse_lo(4'b0010);
        n_vec++;
        if (ovf !== REL) begin
            n_err++;
            $display("FAIL bp_release_ovf: got ovf=%0b, required %0b", ovf, REL);
        end
        n_vec++;
        if ({evt_valid, evt_id} !== {1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL bp_head_hold: got valid=%0b id=%0d, required 1 0", evt_valid, evt_id);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        evt_ready = 1'b1;
        wait_drain();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_drain: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_release();
        do_reset();
        evt_ready = 1'b1;
        push_exp(1, 1'b1);
        pulse_hi(4'b0010);
        tick();
        tick();
        if (REL) push_exp(1, 1'b0);
        pulse_lo(4'b0010);
        wait_drain();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL release_drain: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int   id;
        logic pr;
        do_reset();
        evt_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            id = $urandom_range(0, N - 1);
            pr = REL ? 1'($urandom_range(0, 1)) : 1'b1;
            push_exp(id, pr);
            if (pr) sw_hi = 4'(1 << id);
            else    sw_lo = 4'(1 << id);
            tick();
            sw_hi = '0;
            sw_lo = '0;
            if (k >= 1) begin
                n_vec++;
                if (evt_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_throughput[%0d]: got valid=%0b, required 1", k, evt_valid);
                end
            end
        end
        wait_drain();
        n_vec++;
        if ({ovf, 7'(exp_q.size())} !== 8'd0) begin
            n_err++;
            $display("FAIL b2b_end: got ovf=%0b left=%0d, required 0 0", ovf, exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        sw_hi = 4'b0111;
        tick();
        sw_hi = 4'b0100;   // slot 2 still waiting -> lost
        tick();
        sw_hi = '0;
        tick();
        tick();
        n_vec++;
        if ({evt_valid, ovf} !== 2'b11) begin
            n_err++;
            $display("FAIL areset_pre: got valid=%0b ovf=%0b, required 1 1", evt_valid, ovf);
        end
        #5;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({evt_valid, evt_id, ovf} !== 4'b0000) begin
            n_err++;
            $display("FAIL areset_now: got valid=%0b id=%0d ovf=%0b, required 0 0 0", evt_valid, evt_id, ovf);
        end
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        evt_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_vec++;
            if (evt_valid !== 1'b0) begin
                n_err++;
                $display("FAIL areset_stale[%0d]: got valid=%0b, required 0", c, evt_valid);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_press();
        test_simultaneous();
        test_round_robin();
        test_grant_cycle_capture();
        test_backpressure();
        test_release();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
